// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sharing one mux4 between four 4-bit
// requesters, feeding a single-entry valid/ready output register.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req[3:0], d0..d3      : requester valid bits and data words
//   gnt[3:0]              : one-hot grant (combinational), word captured at edge
//   y, y_valid, y_ready   : registered output word and handshake
//   sel[1:0]              : requester index of the word held in y
//   xfer_cnt[7:0]         : wrapping count of words taken by the consumer
//
// Build option: define MUX4_RR_ARBITER_P0_PRIO_EN to give requester 0
// absolute priority; the default build is pure round-robin.

module mux4 (
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [1:0] s,
    output logic [3:0] y
);

    always_comb begin
        y = d0;
        unique case (s)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

module mux4_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic [3:0] gnt,
    output logic [3:0] y,
    output logic       y_valid,
    input  logic       y_ready,
    output logic [1:0] sel,
    output logic [7:0] xfer_cnt
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] y_q, y_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] cnt_q, cnt_d;

    logic       full;
    logic       take;
    logic       load;
    logic [7:0] req_dup;
    logic [3:0] req_rot;
    logic [1:0] off;
    logic [1:0] win;
    logic [3:0] mux_y;

    assign full = (state_q == S_FULL);

    // Consumer takes the held word this edge.
    assign take = full && y_ready;

    // A new word can be captured when the slot is free or being freed.
    assign load = !reset && (|req) && (!full || y_ready);

    // Rotate requests so bit k is requester (ptr+k) mod 4.
    always_comb begin
        req_dup = {req, req} >> ptr_q;
        req_rot = req_dup[3:0];
    end

    always_comb begin
        off = 2'd0;
        if (req_rot[0]) begin
            off = 2'd0;
        end else if (req_rot[1]) begin
            off = 2'd1;
        end else if (req_rot[2]) begin
            off = 2'd2;
        end else if (req_rot[3]) begin
            off = 2'd3;
        end
    end

    always_comb begin
        win = ptr_q + off;
`ifdef MUX4_RR_ARBITER_P0_PRIO_EN
        if (req[0]) begin
            win = 2'd0;
        end
`endif
    end

    mux4 u_mux4 (
        .d0 (d0),
        .d1 (d1),
        .d2 (d2),
        .d3 (d3),
        .s  (win),
        .y  (mux_y)
    );

    always_comb begin
        gnt = 4'b0000;
        if (load) begin
            gnt = 4'b0001 << win;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        y_d     = y_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;

        if (take) begin
            cnt_d = cnt_q + 8'd1;
        end

        if (load) begin
            state_d = S_FULL;
            y_d     = mux_y;
            sel_d   = win;
            ptr_d   = win + 2'd1;
`ifdef MUX4_RR_ARBITER_P0_PRIO_EN
            // Grants to the priority port leave the rotation untouched.
            if (win == 2'd0) begin
                ptr_d = ptr_q;
            end
`endif
        end else if (take) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
            ptr_q   <= 2'd0;
            y_q     <= 4'd0;
            sel_q   <= 2'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y        = y_q;
    assign y_valid  = full;
    assign sel      = sel_q;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the arbitration rules.

module tb_mux4_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] gnt;
    logic [3:0] y;
    logic       y_valid;
    logic       y_ready;
    logic [1:0] sel;
    logic [7:0] xfer_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int       m_ptr;
    int       m_sel;
    int       m_cnt;
    bit       m_valid;
    bit [3:0] m_y;

    mux4_rr_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .gnt      (gnt),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .sel      (sel),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit [3:0] m_data(input int i);
        case (i)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    // Winner: first requester at or after the pointer, modulo 4.
    function automatic int m_win();
`ifdef MUX4_RR_ARBITER_P0_PRIO_EN
        if (req[0]) return 0;
`endif
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit m_load();
        return !reset && (req != 4'b0) && (!m_valid || y_ready);
    endfunction

    function automatic bit [3:0] m_gnt();
        bit [3:0] g;
        g = 4'b0;
        if (m_load()) g[m_win()] = 1'b1;
        return g;
    endfunction

    // Advance the model by one clock using the current inputs.
    task automatic m_clock();
        int w;
        if (reset) begin
            m_ptr = 0; m_sel = 0; m_cnt = 0;
            m_valid = 0; m_y = 4'h0;
        end else begin
            w = m_win();
            if (m_valid && y_ready) m_cnt = (m_cnt + 1) % 256;
            if (m_load()) begin
                m_y = m_data(w);
                m_sel = w;
                m_valid = 1;
`ifdef MUX4_RR_ARBITER_P0_PRIO_EN
                if (w != 0) m_ptr = (w + 1) % 4;
`else
                m_ptr = (w + 1) % 4;
`endif
            end else if (m_valid && y_ready) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic tick();
        m_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; req = 4'b1111; y_ready = 1;
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL reset_gnt got=%b want=0000", gnt);
            end
            tick();
            checks++;
            if (y_valid !== 1'b0 || y !== 4'h0 || sel !== 2'd0 ||
                xfer_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_state got v=%b y=%h sel=%0d cnt=%0d",
                         y_valid, y, sel, xfer_cnt);
            end
        end
        reset = 0; req = 4'b0000;
        tick();
    endtask

    task automatic test_rotation();
        bit [3:0] want;
        req = 4'b1111; y_ready = 1;
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== m_gnt()) begin
                errors++;
                $display("FAIL rot_gnt%0d got=%b want=%b", c, gnt, m_gnt());
            end
            tick();
`ifdef MUX4_RR_ARBITER_P0_PRIO_EN
            want = 4'h1;
`else
            want = 4'(c % 4 + 1);
`endif
            checks++;
            if (y !== want || y_valid !== 1'b1) begin
                errors++;
                $display("FAIL rot_y%0d got=%h v=%b want=%h", c, y, y_valid, want);
            end
        end
        req = 4'b0000;
        tick();
        checks++;
        if (xfer_cnt !== 8'd8 || y_valid !== 1'b0) begin
            errors++;
            $display("FAIL rot_cnt got=%0d v=%b want=8 v=0", xfer_cnt, y_valid);
        end
    endtask

    task automatic test_backpressure();
        req = 4'b0100; d2 = 4'hA; y_ready = 0;
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0000 || y !== 4'hA || sel !== 2'd2 ||
                y_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall%0d got gnt=%b y=%h sel=%0d v=%b",
                         c, gnt, y, sel, y_valid);
            end
            tick();
        end
        y_ready = 1; d2 = 4'h5;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release_gnt got=%b want=0100", gnt);
        end
        tick();
        checks++;
        if (y !== 4'h5 || y_valid !== 1'b1 || sel !== 2'd2) begin
            errors++;
            $display("FAIL bp_reload got y=%h v=%b sel=%0d want 5/1/2",
                     y, y_valid, sel);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_ptr_wrap();
        int exp_sel[3];
        y_ready = 1;
        req = 4'b1000; d3 = 4'h7;
        tick();
        checks++;
        if (sel !== 2'd3 || y !== 4'h7) begin
            errors++;
            $display("FAIL wrap_r3 got sel=%0d y=%h want 3/7", sel, y);
        end
        req = 4'b1011; d0 = 4'h8; d1 = 4'h9; d3 = 4'hB;
`ifdef MUX4_RR_ARBITER_P0_PRIO_EN
        exp_sel = '{0, 0, 0};
`else
        exp_sel = '{0, 1, 3};
`endif
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== m_gnt() || gnt !== (4'b0001 << exp_sel[c])) begin
                errors++;
                $display("FAIL wrap_gnt%0d got=%b want idx %0d",
                         c, gnt, exp_sel[c]);
            end
            tick();
            checks++;
            if (sel !== 2'(exp_sel[c])) begin
                errors++;
                $display("FAIL wrap_sel%0d got=%0d want=%0d", c, sel, exp_sel[c]);
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        req = 4'b0100; d2 = 4'hC; y_ready = 0;
        tick();
        tick();
        checks++;
        if (y_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_prefill got v=%b want=1", y_valid);
        end
        reset = 1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL mid_gnt_in_reset got=%b want=0000", gnt);
        end
        tick();
        checks++;
        if (y_valid !== 1'b0 || y !== 4'h0 || xfer_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_cleared got v=%b y=%h cnt=%0d", y_valid, y, xfer_cnt);
        end
        reset = 0; req = 4'b1010; y_ready = 1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL mid_first_gnt got=%b want=0010", gnt);
        end
        tick();
        req = 4'b0000;
        tick();
    endtask

`ifdef MUX4_RR_ARBITER_P0_PRIO_EN
    task automatic test_p0_prio();
        reset = 1; tick(); reset = 0;
        req = 4'b1111; y_ready = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0001) begin
                errors++;
                $display("FAIL prio_p0_%0d got=%b want=0001", c, gnt);
            end
            tick();
        end
        req = 4'b1110;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== (4'b0001 << c)) begin
                errors++;
                $display("FAIL prio_rr%0d got=%b want idx %0d", c, gnt, c);
            end
            tick();
        end
        req = 4'b0000;
        tick();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom_range(0, 49) == 0);
            req     = 4'($urandom);
            y_ready = ($urandom_range(0, 3) != 0);
            d0 = 4'($urandom); d1 = 4'($urandom);
            d2 = 4'($urandom); d3 = 4'($urandom);
            @(negedge clk);
            checks++;
            if (gnt !== m_gnt()) begin
                errors++;
                $display("FAIL rnd_gnt%0d got=%b want=%b", c, gnt, m_gnt());
            end
            tick();
            checks++;
            if (y_valid !== m_valid || xfer_cnt !== 8'(m_cnt) ||
                (m_valid && (y !== m_y || sel !== 2'(m_sel)))) begin
                errors++;
                $display("FAIL rnd_out%0d got v=%b y=%h sel=%0d cnt=%0d want v=%b y=%h sel=%0d cnt=%0d",
                         c, y_valid, y, sel, xfer_cnt, m_valid, m_y, m_sel, m_cnt);
            end
        end
        reset = 0; req = 4'b0000;
        tick();
    endtask

    initial begin
        reset = 1; req = 4'b0; y_ready = 0;
        d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
        m_ptr = 0; m_sel = 0; m_cnt = 0; m_valid = 0; m_y = 4'h0;
        #1;
        test_reset();
        test_rotation();
        test_backpressure();
        test_ptr_wrap();
        test_reset_mid();
`ifdef MUX4_RR_ARBITER_P0_PRIO_EN
        test_p0_prio();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one `mux4` datapath between four 4-bit requesters. It instantiates `mux4` internally and drives its select from the arbitration result. The selected word is captured into a single-entry output register with a valid/ready handshake. The block sits between four producer ports and one downstream consumer, and supports one transfer per cycle at full throughput.

## Interface
Parameters:
- none; widths are fixed at 4 data bits and 4 requesters, matching `mux4`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req` input 4: `req[i]` means requester i has a valid word on `d<i>`.
- `d0`, `d1`, `d2`, `d3` input 4 each: requester data words.
- `gnt` output 4: one-hot, combinational; `gnt[i]` high means `d<i>` is captured at this clock edge.
- `y` output 4: registered output word.
- `y_valid` output 1: `y` holds an untaken word.
- `y_ready` input 1: consumer accepts `y` at this edge when `y_valid` is also high.
- `sel` output 2: index of the requester whose word is in `y`.
- `xfer_cnt` output 8: count of words accepted by the consumer, wrapping.

## Operation
- Output stage has two states:
  - EMPTY: `y_valid`=0.
  - FULL: `y_valid`=1.
- `load` = (|req) && (!y_valid || y_ready). When `load` is high, exactly one `gnt` bit is high; otherwise `gnt`=0.
- Arbitration: a 2-bit pointer `ptr` is the highest-priority index. The winner is the first i with `req[i]`=1, searching in order ptr, ptr+1, ptr+2, ptr+3, all modulo 4.
- Datapath: the winner index drives the internal `mux4` select as s = winner. `y` captures the `mux4` output on `load`.
- On `load`:
  - `y` <= selected word; `sel` <= winner; `y_valid` <= 1.
  - `ptr` <= winner+1 mod 4, wrapping 3 to 0.
- FULL with `y_ready`=1 and no `req`: `y_valid` <= 0, and the state goes to EMPTY.
- FULL with `y_ready`=0: `y`, `sel` and `y_valid` hold; `gnt`=0; `ptr` holds.
- FULL with `y_ready`=1 and `req`≠0: accept and reload at the same edge. The state stays FULL with the new word.
- `xfer_cnt` increments by 1 on every edge where `y_valid && y_ready`, including simultaneous reloads. It wraps from 255 to 0.
- Requester rule:
  - Hold `req[i]` and `d<i>` stable until a cycle in which `gnt[i]`=1.
  - Keeping `req[i]` high after a grant requests another transfer.
  - The arbiter does not require `req` to be stable; a dropped request simply loses eligibility.
- Reset, including mid-operation: `y`=0, `sel`=0, `y_valid`=0, `ptr`=0, `xfer_cnt`=0. A word pending in `y` is discarded.
- While `reset` is high, `gnt`=0 regardless of `req`.

## Timing
- `gnt` is combinational from `req`, `y_valid`, `y_ready` and `ptr`. There is no combinational path from any `d` to any output.
- Latency: a word on `d<i>` granted at edge N appears on `y` with `y_valid`=1 in cycle N+1.
- Throughput: with `y_ready` held high, one word per cycle.
- Fairness: with all four requests continuously high, grants rotate 0,1,2,3,0,…. Any waiting requester is granted within 4 loads.
- `y_ready` while `y_valid`=0 has no effect and is not counted.

## Configuration
- Macro: `MUX4_RR_ARBITER_P0_PRIO_EN`.
- Defined: requester 0 has absolute priority.
  - If `req[0]`=1 on a `load` cycle, the winner is 0 regardless of `ptr`.
  - `ptr` does not update on grants to 0.
  - Other requesters use round-robin as above. Starvation of 1–3 is permitted by design.
- Not defined: pure round-robin for all four requesters, as described in Operation.

## Test plan
- Reset check: hold `reset`=1 for 2 cycles with `req`=4'b1111 → `gnt`=0, `y_valid`=0, `y`=0, `sel`=0, `xfer_cnt`=0.
- Rotation:
  - Stimulus: `req`=4'b1111; d0=4'h1, d1=4'h2, d2=4'h3, d3=4'h4; `y_ready`=1 for 8 cycles.
  - Expected: `y` sequence is 1,2,3,4,1,2,3,4 on consecutive cycles; `xfer_cnt`=8 one cycle after the last accept.
- Backpressure:
  - Stimulus: `req`=4'b0100, d2=4'hA, `y_ready`=0 for 5 cycles, then 1.
  - Expected: `y`=4'hA and `sel`=2 are held with `y_valid`=1 and `gnt`=0 throughout the stall. On release, `gnt[2]`=1 and the next word loads the same edge.
- Pointer wrap:
  - Stimulus: grant requester 3 alone, then present `req`=4'b1011.
  - Expected: requester 0 wins, then 1, then 3.
- Reset mid-transfer: assert `reset` while `y_valid`=1 and `y_ready`=0 → next cycle `y_valid`=0 and `ptr`=0. After release, `req`=4'b1010 grants 1 first.
- Macro test, with `MUX4_RR_ARBITER_P0_PRIO_EN` defined:
  - Stimulus: `req`=4'b1111 for 4 cycles.
  - Expected: all four grants go to 0. Dropping `req[0]` then grants 1, 2, 3 in turn.
